dino_game_ctrl: RTL and testbench

//  Central sequencer for the T-rex game: owns the game-state FSM, the frame-sampled collision latch,
//  the BCD score/hi-score, the speed level, and obstacle spawn scheduling. It feeds gamestate/speed to
//  the draw blocks and issues spawn requests to the obstacle datapath over a valid/ready handshake.
//  It sits between the debounced PS/2 controls, the per-pixel draw hit flags and the VGA frame timing.

---
 rtl/dino_pkg.sv | 25 ++
 rtl/lfsr16.sv | 33 +++
 rtl/dino_game_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// ---------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the T-rex game sequencer and its neighbours:
//   gs_e        game-state encoding driven on the gamestate bus
//   OBS_*       obstacle type codes carried on spawn_type
//   BCD_MAX     saturation value of the 4-digit BCD score
// ---------------------------------------------------------------------------
package dino_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_RUN  = 2'b01,
        GS_DEAD = 2'b10
    } gs_e;

    localparam logic [2:0] OBS_CAC1S   = 3'd0;
    localparam logic [2:0] OBS_CAC2S   = 3'd1;
    localparam logic [2:0] OBS_CAC1B   = 3'd2;
    localparam logic [2:0] OBS_CAC2B   = 3'd3;
    localparam logic [2:0] OBS_BIRD_LO = 3'd4;
    localparam logic [2:0] OBS_BIRD_HI = 3'd5;

    localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), one step per clock.
// Ports:
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset, loads SEED
//   q     out  current register value
// SEED must be non-zero or the register locks up at all-zeros.
// ---------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Tap positions 16,14,13,11 are bits 15,13,12,10 in zero-based numbering.
    assign q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    assign q   = q_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/dino_game_ctrl.sv
// ---------------------------------------------------------------------------
// dino_game_ctrl
// Central sequencer of the T-rex game: game-state FSM, frame-sampled
// collision latch, BCD score / hi-score, speed level and obstacle spawn
// scheduling towards the obstacle datapath.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   frame_tick     1-cycle pulse at start of vertical blanking
//   pixel_valid    current pixel address is in the visible area
//   dino_px        dino sprite opaque at current pixel
//   obs_px         obstacle sprite opaque at current pixel
//   jump_req       debounced jump level
//   restart_req    debounced enter level
//   spawn_ready    obstacle datapath can accept an obstacle
//   spawn_valid    spawn request pending
//   spawn_type     obstacle type (OBS_* code)
//   gamestate      current FSM state (gs_e encoding)
//   collision      collision latched for the current game
//   speed          scroll speed level
//   score, hiscore 4-digit BCD score and best score
// Spawn handshake: a transfer happens on every clock edge where spawn_valid
// and spawn_ready are both high; spawn_valid/spawn_type hold unchanged until
// then, and spawn_valid drops on the following cycle. spawn_valid never
// depends combinationally on spawn_ready.
// ---------------------------------------------------------------------------
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int          SCORE_DIV  = 6,
    parameter int          SPEED_MIN  = 1,
    parameter int          SPEED_MAX  = 8,
    parameter int          BIRD_SPEED = 3,
    parameter int          GAP_MIN    = 40,
    parameter int          DEAD_HOLD  = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_tick,
    input  logic        pixel_valid,
    input  logic        dino_px,
    input  logic        obs_px,
    input  logic        jump_req,
    input  logic        restart_req,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [2:0]  spawn_type,
    output logic [1:0]  gamestate,
    output logic        collision,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic [15:0] hiscore
);

    localparam int FC_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int DC_W  = $clog2(DEAD_HOLD + 1);
    localparam int GAP_W = 8;

    // BCD +1 with ripple carry across the four digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Raw LFSR bits -> obstacle type. 6/7 fold onto the small cacti; birds
    // are only allowed once the game has sped up.
    function automatic logic [2:0] spawn_map(input logic [2:0] raw, input logic [3:0] spd);
        logic [2:0] t;
        case (raw)
            3'd6:    t = OBS_CAC1S;
            3'd7:    t = OBS_CAC2S;
            default: t = raw;
        endcase
        if (spd < 4'(BIRD_SPEED)) begin
            if (t == OBS_BIRD_LO) begin
                t = OBS_CAC1S;
            end else if (t == OBS_BIRD_HI) begin
                t = OBS_CAC2S;
            end
        end
        return t;
    endfunction

    // Frames until the next spawn: random extension shortened by speed,
    // never below half the minimum gap.
    function automatic logic [GAP_W-1:0] gap_reload(input logic [5:0] r, input logic [3:0] spd);
        int g;
        g = GAP_MIN + int'(r) - 2 * int'(spd);
        if (g < GAP_MIN / 2) begin
            g = GAP_MIN / 2;
        end
        return GAP_W'(g);
    endfunction

    gs_e              state_q, state_d;
    logic             hit_acc_q, hit_acc_d;
    logic             collision_q, collision_d;
    logic [15:0]      score_q, score_d;
    logic [15:0]      hiscore_q, hiscore_d;
    logic [3:0]       speed_q, speed_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DC_W-1:0]  dead_cnt_q, dead_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             spawn_valid_q, spawn_valid_d;
    logic [2:0]       spawn_type_q, spawn_type_d;

    logic [15:0]      lfsr;
    logic             lfsr_hi_unused;
    logic             hit_now;
    logic             hit_eff;
    logic             start_game;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .q    (lfsr)
    );

    assign lfsr_hi_unused = ^lfsr[15:6];

    assign hit_now = (state_q == GS_RUN) & pixel_valid & dino_px & obs_px;
    // A hit in the same cycle as frame_tick belongs to the frame being closed.
    assign hit_eff = hit_acc_q | hit_now;

    always_comb begin
        state_d       = state_q;
        hit_acc_d     = hit_eff;
        collision_d   = collision_q;
        score_d       = score_q;
        hiscore_d     = hiscore_q;
        speed_d       = speed_q;
        frame_cnt_d   = frame_cnt_q;
        dead_cnt_d    = dead_cnt_q;
        gap_d         = gap_q;
        spawn_valid_d = spawn_valid_q;
        spawn_type_d  = spawn_type_q;
        start_game    = 1'b0;

        if (frame_tick) begin
            hit_acc_d = 1'b0;
        end

        case (state_q)
            GS_IDLE: begin
                if (jump_req || restart_req) begin
                    state_d    = GS_RUN;
                    start_game = 1'b1;
                end
            end

            GS_RUN: begin
                if (frame_tick && hit_eff) begin
                    // Collision wins over scoring and spawning on this tick.
                    state_d       = GS_DEAD;
                    collision_d   = 1'b1;
                    dead_cnt_d    = '0;
                    spawn_valid_d = 1'b0;
                    if (score_q > hiscore_q) begin
                        hiscore_d = score_q;
                    end
                end else begin
                    if (frame_tick) begin
                        if (frame_cnt_q == FC_W'(SCORE_DIV - 1)) begin
                            frame_cnt_d = '0;
                            if (score_q != BCD_MAX) begin
                                score_d = bcd_inc(score_q);
                                // Tens and units both 9: hundreds digit rolls.
                                if ((score_q[7:0] == 8'h99) && (speed_q < 4'(SPEED_MAX))) begin
                                    speed_d = speed_q + 4'd1;
                                end
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FC_W'(1);
                        end
                    end

                    if (spawn_valid_q) begin
                        if (spawn_ready) begin
                            spawn_valid_d = 1'b0;
                            gap_d         = gap_reload(lfsr[5:0], speed_q);
                        end
                    end else if (frame_tick) begin
                        if (gap_q == '0) begin
                            spawn_valid_d = 1'b1;
                            spawn_type_d  = spawn_map(lfsr[2:0], speed_q);
                        end else begin
                            gap_d = gap_q - GAP_W'(1);
                        end
                    end
                end
            end

            GS_DEAD: begin
                if (restart_req && (dead_cnt_q >= DC_W'(DEAD_HOLD))) begin
                    state_d    = GS_RUN;
                    start_game = 1'b1;
                end else if (frame_tick && (dead_cnt_q < DC_W'(DEAD_HOLD))) begin
                    dead_cnt_d = dead_cnt_q + DC_W'(1);
                end
            end

            default: begin
                state_d = GS_IDLE;
            end
        endcase

        if (start_game) begin
            hit_acc_d     = 1'b0;
            collision_d   = 1'b0;
            score_d       = '0;
            speed_d       = 4'(SPEED_MIN);
            frame_cnt_d   = '0;
            gap_d         = GAP_W'(GAP_MIN);
            spawn_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= GS_IDLE;
            hit_acc_q     <= 1'b0;
            collision_q   <= 1'b0;
            score_q       <= '0;
            hiscore_q     <= '0;
            speed_q       <= 4'(SPEED_MIN);
            frame_cnt_q   <= '0;
            dead_cnt_q    <= '0;
            gap_q         <= GAP_W'(GAP_MIN);
            spawn_valid_q <= 1'b0;
            spawn_type_q  <= '0;
        end else begin
            state_q       <= state_d;
            hit_acc_q     <= hit_acc_d;
            collision_q   <= collision_d;
            score_q       <= score_d;
            hiscore_q     <= hiscore_d;
            speed_q       <= speed_d;
            frame_cnt_q   <= frame_cnt_d;
            dead_cnt_q    <= dead_cnt_d;
            gap_q         <= gap_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_type_q  <= spawn_type_d;
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_type  = spawn_type_q;
    assign gamestate   = state_q;
    assign collision   = collision_q;
    assign speed       = speed_q;
    assign score       = score_q;
    assign hiscore     = hiscore_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
module tb_dino_game_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int GAP_MIN   = 40;
  localparam int DEAD_HOLD = 30;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        dino_px = 1'b0;
  logic        obs_px = 1'b0;
  logic        jump_req = 1'b0;
  logic        restart_req = 1'b0;
  logic        spawn_ready = 1'b0;
  logic        spawn_valid;
  logic [2:0]  spawn_type;
  logic [1:0]  gamestate;
  logic        collision;
  logic [3:0]  speed;
  logic [15:0] score;
  logic [15:0] hiscore;

  always #5 clk = ~clk;

  dino_game_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_tick  (frame_tick),
    .pixel_valid (pixel_valid),
    .dino_px     (dino_px),
    .obs_px      (obs_px),
    .jump_req    (jump_req),
    .restart_req (restart_req),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .gamestate   (gamestate),
    .collision   (collision),
    .speed       (speed),
    .score       (score),
    .hiscore     (hiscore)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  logic [15:0] m_lfsr;
  int m_state = 0;
  int m_points = 0;
  int m_hi = 0;
  int m_div = 0;
  int m_speed = 1;
  int m_gap = GAP_MIN;
  int m_dead = 0;
  int m_ticks = 0;
  bit m_valid = 1'b0;
  bit m_coll = 1'b0;
  bit m_hit = 1'b0;
  logic [2:0] last_type = 3'd0;
  int targets[8] = '{5, 4, 7, 6, 3, 2, 1, 0};
  int t_idx = 0;

  // Reference LFSR: seed on reset, one Fibonacci step (taps 16,14,13,11) per clock.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int p);
    return {4'(p / 1000), 4'((p / 100) % 10), 4'((p / 10) % 10), 4'(p % 10)};
  endfunction

  function automatic logic [2:0] exp_type(input logic [2:0] r, input int spd);
    case (r)
      3'd6:    return 3'd0;
      3'd7:    return 3'd1;
      3'd4:    return (spd >= 3) ? 3'd4 : 3'd0;
      3'd5:    return (spd >= 3) ? 3'd5 : 3'd1;
      default: return r;
    endcase
  endfunction

  // Spawn monitor: every rising spawn_valid pops one expected type.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (spawn_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("spawn_queue", 32'(exp_q.size()), 32'd1);
        else                   check("spawn_type", 32'(spawn_type), 32'(exp_q.pop_front()));
      end
      prev_valid = spawn_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_points = 0; m_hi = 0; m_div = 0; m_speed = 1;
    m_gap = GAP_MIN; m_dead = 0; m_ticks = 0; m_valid = 0; m_coll = 0; m_hit = 0;
    exp_q.delete();
  endtask

  task automatic model_start();
    m_state = 1; m_points = 0; m_div = 0; m_speed = 1; m_gap = GAP_MIN;
    m_valid = 0; m_coll = 0; m_hit = 0; m_ticks = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_gamestate"}, 32'(gamestate), 32'(m_state));
    check({tag, "_score"}, 32'(score), 32'(to_bcd(m_points)));
    check({tag, "_speed"}, 32'(speed), 32'(m_speed));
    check({tag, "_collision"}, 32'(collision), 32'(m_coll));
    check({tag, "_hiscore"}, 32'(hiscore), 32'(to_bcd(m_hi)));
    check({tag, "_spawn_valid"}, 32'(spawn_valid), 32'(m_valid));
  endtask

  // One frame_tick. target>=0 delays an issuing tick until lfsr[2:0]==target.
  task automatic tick(input int target, input bit with_hit, output bit issued);
    bit hit;
    hit = m_hit || with_hit;
    issued = (m_state == 1) && !hit && !m_valid && (m_gap == 0);
    if (issued && target >= 0) begin
      int w = 0;
      while (m_lfsr[2:0] != 3'(target) && w < 200) begin
        step();
        w++;
      end
    end
    if (issued) begin
      last_type = exp_type(m_lfsr[2:0], m_speed);
      exp_q.push_back(last_type);
    end
    frame_tick = 1'b1;
    if (with_hit) begin pixel_valid = 1'b1; dino_px = 1'b1; obs_px = 1'b1; end
    step();
    frame_tick = 1'b0; pixel_valid = 1'b0; dino_px = 1'b0; obs_px = 1'b0;
    case (m_state)
      1: begin
        if (hit) begin
          m_state = 2; m_coll = 1; m_dead = 0; m_valid = 0;
          if (m_points > m_hi) m_hi = m_points;
        end else begin
          m_ticks++;
          m_div++;
          if (m_div == 6) begin
            m_div = 0;
            if (m_points < 9999) begin
              m_points++;
              if ((m_points % 100 == 0) && m_speed < 8) m_speed++;
            end
          end
          if (issued) m_valid = 1;
          else if (!m_valid) m_gap--;
        end
      end
      2: if (m_dead < DEAD_HOLD) m_dead++;
      default: ;
    endcase
    m_hit = 0;
    check_state("tick");
    step();
  endtask

  task automatic accept();
    logic [15:0] lf;
    int g;
    spawn_ready = 1'b1;
    lf = m_lfsr;
    step();
    spawn_ready = 1'b0;
    m_valid = 0;
    g = GAP_MIN + int'(lf[5:0]) - 2 * m_speed;
    if (g < GAP_MIN / 2) g = GAP_MIN / 2;
    m_gap = g;
    check("handshake_drop", 32'(spawn_valid), 32'd0);
  endtask

  task automatic run_until(input int n, input bit auto_accept);
    bit iss;
    while (m_ticks < n) begin
      tick(targets[t_idx], 1'b0, iss);
      if (iss) t_idx = (t_idx + 1) % 8;
      if (auto_accept && m_valid) accept();
    end
  endtask

  task automatic press(input bit use_jump);
    if (use_jump) jump_req = 1'b1;
    else          restart_req = 1'b1;
    step();
    jump_req = 1'b0; restart_req = 1'b0;
    if (m_state == 0 || (m_state == 2 && m_dead >= DEAD_HOLD)) model_start();
    check("press_gamestate", 32'(gamestate), 32'(m_state));
  endtask

  task automatic hit_pulse(input bit pv);
    pixel_valid = pv; dino_px = 1'b1; obs_px = 1'b1;
    step();
    pixel_valid = 1'b0; dino_px = 1'b0; obs_px = 1'b0;
    if (pv && m_state == 1) m_hit = 1;
    repeat (3) step();
    check("hit_no_tick_gamestate", 32'(gamestate), 32'(m_state));
  endtask

  task automatic dead_ticks(input int n);
    bit iss;
    for (int i = 0; i < n; i++) tick(-1, 1'b0, iss);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit iss;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_spawn_type", 32'(spawn_type), 32'd0);
    check_state("reset");

    dead_ticks(2);
    press(1'b1);

    run_until(6, 1'b1);
    check("six_ticks_score", 32'(score), 32'h0001);

    // First spawn: ready held low for 5 frames.
    run_until(40, 1'b0);
    tick(5, 1'b0, iss);
    check("first_spawn_issued", 32'(spawn_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(-1, 1'b0, iss);
      check("hold_valid", 32'(spawn_valid), 32'd1);
      check("hold_type", 32'(spawn_type), 32'(last_type));
    end
    accept();

    run_until(600, 1'b1);
    check("t600_score", 32'(score), 32'h0100);
    check("t600_speed", 32'(speed), 32'd2);

    run_until(1200, 1'b1);
    check("t1200_speed", 32'(speed), 32'd3);
    t_idx = 0;
    run_until(1400, 1'b1);

    // Off-screen overlap is ignored; an on-screen one is latched until the tick.
    hit_pulse(1'b0);
    tick(-1, 1'b0, iss);
    hit_pulse(1'b1);
    tick(-1, 1'b0, iss);
    check("dead_state", 32'(gamestate), 32'd2);
    check("dead_hiscore", 32'(hiscore), 32'h0233);

    dead_ticks(10);
    press(1'b0);
    check("early_restart_ignored", 32'(gamestate), 32'd2);
    dead_ticks(20);
    press(1'b0);
    check("restart_score", 32'(score), 32'h0000);
    check("restart_speed", 32'(speed), 32'd1);
    check("restart_collision", 32'(collision), 32'd0);

    // Hit coincident with the tick counts for this frame; hiscore keeps the best.
    run_until(8, 1'b1);
    tick(-1, 1'b1, iss);
    check("same_cycle_hit", 32'(gamestate), 32'd2);
    check("hiscore_kept", 32'(hiscore), 32'h0233);

    dead_ticks(DEAD_HOLD);
    press(1'b0);
    run_until(40, 1'b0);
    tick(7, 1'b0, iss);
    check("pre_reset_valid", 32'(spawn_valid), 32'd1);

    // Asynchronous reset mid-cycle with a spawn pending.
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    model_reset();
    check("async_spawn_type", 32'(spawn_type), 32'd0);
    check_state("async_rst");
    #20 rstn = 1'b1;
    step();
    step();
    check_state("post_release");

    press(1'b1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
